demux8_hs: RTL and testbench
============================

Name: demux8_hs

Overview:
- Eight-way demultiplexing write port with a valid/ready handshake on every channel; this is the distribution counterpart of the 8-to-1 operand select.
- Accepts one `datasize-wide word plus a 3-bit destination select (or a broadcast flag) and holds the word in a one-entry buffer.
- Presents the word to the chosen destination(s) until each one accepts it.
- Used for write-back and result distribution to eight consumers, e.g. register banks or functional-unit ports.

Parameters:
- muxsize, `datasize (from define.v), data word width.
- cntsize, 16, width of the completed-word counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- inp  input  muxsize  data word to distribute.
- sel  input  3  destination index 0..7; ignored when bcast=1.
- bcast  input  1  deliver the word to all eight destinations.
- inp_vld  input  1  upstream word valid.
- inp_rdy  output  1  block can take a word this cycle.
- outp0..outp7  output  muxsize each  per-destination data.
- outp_vld  output  8  per-destination valid, bit i pairs with outp<i>.
- outp_rdy  input  8  per-destination ready.
- busy  output  1  a word is held (pending mask non-zero).
- done_cnt  output  cntsize  count of fully delivered words.

Behaviour:
- State:
  - data_q[muxsize-1:0]
  - pend_q[7:0], the mask of destinations still owed the current word
  - done_cnt_q
- Reset (rst_n=0, asynchronous): data_q=0, pend_q=0, done_cnt_q=0. Hence outp_vld=0, all outp<i>=0, busy=0 and inp_rdy=1 once released.
- Reset mid-delivery discards the held word; a partially delivered broadcast is not completed.
- Output transfer on channel i: a cycle with outp_vld[i] & outp_rdy[i].
  - remain = pend_q & ~outp_rdy
  - A word completes in a cycle where pend_q!=0 and remain==0.
- Output signals:
  - outp_vld = pend_q
  - outp<i> = data_q when pend_q[i], else all zeros
  - Outputs are driven, never high-Z; non-selected outputs are 0.
- Ready: inp_rdy = (pend_q==0) | (remain==0).
  - This is a combinational path from outp_rdy to inp_rdy, so back-to-back words run at full throughput.
  - outp_vld must not depend on outp_rdy.
- Input accept (inp_vld & inp_rdy):
  - data_q <= inp
  - pend_q <= bcast ? 8'hFF : onehot(sel)
  - Latency: accept at edge N, outp_vld visible after edge N, first transfer possible in cycle N+1.
- No accept, pend_q!=0: pend_q <= remain. data_q holds. Broadcast destinations may accept in different cycles, in any order.
- Simultaneous completion and accept in the same cycle: the new word replaces the old. There is no bubble, and the old valid bits do not linger.
- inp_vld=1 while inp_rdy=0: no state change; upstream must hold inp, sel and bcast stable.
- done_cnt: increments by 1 on each completion cycle and wraps from 2^cntsize-1 to 0.
- busy = (pend_q!=0).
- Implicit two-state FSM:
  - EMPTY (pend_q==0): goes to HOLD on accept.
  - HOLD: goes to EMPTY on completion without accept; stays in HOLD on completion with accept or on partial progress.

Decomposition:
- define.v holds `datasize and a new `demux_ways (8). No package is needed beyond these constants.
- One sub-module: dec3to8, a combinational 3-to-8 one-hot decoder with an enable. It is reusable for the pend_q load and elsewhere in the datapath.
- Counter and mask logic stay inline in demux8_hs.

Test Plan:
- Reset: hold rst_n=0 mid-word (pend_q=8'h10), then release → outp_vld=0, outp4=0, done_cnt=0, inp_rdy=1; assert rst_n asynchronously between edges → outputs clear immediately.
- Unicast: inp=16'hA5A5, sel=3, bcast=0, outp_rdy=8'h08 → outp_vld=8'h08 and outp3=A5A5 for exactly one cycle, other outputs 0, done_cnt=1.
- Backpressure: sel=6, outp_rdy=0 for 5 cycles → outp_vld=8'h40 held, inp_rdy=0, data stable; raise outp_rdy[6] → completes, inp_rdy=1 in the same cycle.
- Broadcast, staggered: bcast=1, inp=16'h1234; outp_rdy=8'h0F, then 8'h30, then 8'hC0 → outp_vld=FF, F0, C0, 00 across the cycles; done_cnt increments only on the third cycle.
- Streaming: inp_vld=1 continuously, sel=0,1,2..., outp_rdy=8'hFF → one word delivered per cycle with no bubbles, outp_vld one-hot advancing each cycle, done_cnt +1 per cycle.
- Counter wrap: preload via 65535 unicast deliveries (or force) → next completion gives done_cnt=0.

Source files
------------

// File: rtl/demux8_hs_pkg.sv
// Shared constants and types for the eight-way handshake demultiplexer.
// Imported by the interface, the top module and the bench.
package demux8_hs_pkg;

    localparam int datasize   = 16;
    localparam int demux_ways = 8;
    localparam int cntsize    = 16;

    // st_empty: no word held; st_hold: at least one destination is still owed the word
    typedef enum logic {
        st_empty = 1'b0,
        st_hold  = 1'b1
    } state_e;

endpackage

// File: rtl/demux8_hs_if.sv
// Upstream and per-destination handshake bundle for demux8_hs.
// Handshake: a transfer happens in any cycle where valid and ready are both high.
// A valid source keeps its payload stable until that transfer.
// Valid never waits on ready. Ready may depend combinationally on valid.
interface demux8_hs_if
    import demux8_hs_pkg::*;
#(
    parameter int muxsize = datasize,
    parameter int cntsize = demux8_hs_pkg::cntsize
);

    logic [muxsize-1:0]    inp;
    logic [2:0]            sel;
    logic                  bcast;
    logic                  inp_vld;
    logic                  inp_rdy;
    logic [muxsize-1:0]    outp0, outp1, outp2, outp3;
    logic [muxsize-1:0]    outp4, outp5, outp6, outp7;
    logic [demux_ways-1:0] outp_vld;
    logic [demux_ways-1:0] outp_rdy;
    logic                  busy;
    logic [cntsize-1:0]    done_cnt;

    // Environment side: the upstream producer together with the eight consumers.
    modport master (
        output inp, sel, bcast, inp_vld, outp_rdy,
        input  inp_rdy, outp0, outp1, outp2, outp3, outp4, outp5, outp6, outp7,
        input  outp_vld, busy, done_cnt
    );

    modport slave (
        input  inp, sel, bcast, inp_vld, outp_rdy,
        output inp_rdy, outp0, outp1, outp2, outp3, outp4, outp5, outp6, outp7,
        output outp_vld, busy, done_cnt
    );

endinterface

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder with an enable.
// The output is all zeros when the enable is low.
module dec3to8 (
    input  logic [2:0] sel,
    input  logic       en,
    output logic [7:0] dec
);

    always_comb begin
        dec = '0;
        if (en) dec[sel] = 1'b1;
    end

endmodule

// File: rtl/demux8_hs.sv
// One-entry buffered 1-to-8 distributor with unicast or broadcast delivery.
// Each destination keeps its valid high until it accepts the held word.
module demux8_hs
    import demux8_hs_pkg::*;
#(
    parameter int muxsize = datasize,
    parameter int cntsize = demux8_hs_pkg::cntsize
) (
    input  logic        clk,
    input  logic        rst_n,
    demux8_hs_if.slave  bus,
    output state_e      state
);

    logic [muxsize-1:0]    data_q;
    logic [demux_ways-1:0] pend_q;
    logic [cntsize-1:0]    done_cnt_q;
    state_e                state_q;

    logic [demux_ways-1:0] remain;
    logic [demux_ways-1:0] sel_dec;
    logic [demux_ways-1:0] load_mask;
    logic                  complete;
    logic                  rdy;
    logic                  accept;

    dec3to8 u_dec (
        .sel (bus.sel),
        .en  (~bus.bcast),
        .dec (sel_dec)
    );

    // Ready looks through outp_rdy so a word finishing this cycle frees the slot at once.
    always_comb begin
        remain    = pend_q & ~bus.outp_rdy;
        complete  = (pend_q != '0) && (remain == '0);
        rdy       = (pend_q == '0) || (remain == '0);
        accept    = bus.inp_vld & rdy;
        load_mask = sel_dec | {demux_ways{bus.bcast}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            pend_q     <= '0;
            done_cnt_q <= '0;
            state_q    <= st_empty;
        end else begin
            // A new word overwrites a just-completed one, so no stale valid bits survive.
            if (accept) begin
                data_q <= bus.inp;
                pend_q <= load_mask;
            end else if (pend_q != '0) begin
                pend_q <= remain;
            end

            if (complete) done_cnt_q <= done_cnt_q + 1'b1;

            case (state_q)
                st_empty: if (accept) state_q <= st_hold;
                st_hold:  if (complete && !accept) state_q <= st_empty;
                default:  state_q <= st_empty;
            endcase
        end
    end

    assign bus.inp_rdy  = rdy;
    assign bus.outp_vld = pend_q;
    assign bus.busy     = (pend_q != '0);
    assign bus.done_cnt = done_cnt_q;
    assign state        = state_q;

    assign bus.outp0 = pend_q[0] ? data_q : '0;
    assign bus.outp1 = pend_q[1] ? data_q : '0;
    assign bus.outp2 = pend_q[2] ? data_q : '0;
    assign bus.outp3 = pend_q[3] ? data_q : '0;
    assign bus.outp4 = pend_q[4] ? data_q : '0;
    assign bus.outp5 = pend_q[5] ? data_q : '0;
    assign bus.outp6 = pend_q[6] ? data_q : '0;
    assign bus.outp7 = pend_q[7] ? data_q : '0;

endmodule

// File: tb/tb_demux8_hs.sv
// Directed bench for demux8_hs: a scoreboard of {channel, data} expectations
// is filled on every accepted word and drained on every output transfer.
module tb_demux8_hs;
  import demux8_hs_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux8_hs_if #(.muxsize(16), .cntsize(16)) bus ();
  state_e state;

  demux8_hs #(.muxsize(16), .cntsize(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .state (state)
  );

  int checks = 0;
  int failures = 0;
  logic [18:0] exp_q[$];

  logic [15:0] outs [8];
  assign outs[0] = bus.outp0;
  assign outs[1] = bus.outp1;
  assign outs[2] = bus.outp2;
  assign outs[3] = bus.outp3;
  assign outs[4] = bus.outp4;
  assign outs[5] = bus.outp5;
  assign outs[6] = bus.outp6;
  assign outs[7] = bus.outp7;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.outp_vld[i] && bus.outp_rdy[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_extra: ch=%0d data=%0h expected no transfer", i, outs[i]);
          end else begin
            logic [18:0] e;
            e = exp_q.pop_front();
            chk("sb_xfer", {13'd0, 3'(i), outs[i]}, {13'd0, e});
          end
        end
      end
      if (bus.inp_vld && bus.inp_rdy) begin
        if (bus.bcast) begin
          for (int j = 0; j < 8; j++) exp_q.push_back({3'(j), bus.inp});
        end else begin
          exp_q.push_back({bus.sel, bus.inp});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [15:0] data, input logic [2:0] s, input logic b);
    logic ok;
    bus.inp     = data;
    bus.sel     = s;
    bus.bcast   = b;
    bus.inp_vld = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus.inp_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("put_accept", {31'd0, ok}, 32'd1);
    @(posedge clk);
    #1;
    bus.inp_vld = 1'b0;
    bus.bcast   = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n        = 1'b0;
    bus.inp      = '0;
    bus.sel      = '0;
    bus.bcast    = 1'b0;
    bus.inp_vld  = 1'b0;
    bus.outp_rdy = '0;
    repeat (2) step();
    chk("rst_vld", {24'd0, bus.outp_vld}, 32'h0);
    chk("rst_rdy", {31'd0, bus.inp_rdy}, 32'd1);
    rst_n = 1'b1;
    step();

    // Reset in the middle of an undelivered word
    put_word(16'hC0DE, 3'd4, 1'b0);
    @(negedge clk);
    chk("mid_vld", {24'd0, bus.outp_vld}, 32'h10);
    chk("mid_outp4", {16'd0, outs[4]}, 32'hC0DE);
    chk("mid_state", {31'd0, state}, {31'd0, st_hold});
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_vld", {24'd0, bus.outp_vld}, 32'h0);
    chk("arst_outp4", {16'd0, outs[4]}, 32'h0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_state", {31'd0, state}, {31'd0, st_empty});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", {31'd0, bus.inp_rdy}, 32'd1);
    chk("rel_cnt", {16'd0, bus.done_cnt}, 32'd0);
    chk("rel_vld", {24'd0, bus.outp_vld}, 32'h0);
    step();

    // Unicast with the destination already ready
    bus.outp_rdy = 8'h08;
    put_word(16'hA5A5, 3'd3, 1'b0);
    @(negedge clk);
    chk("uni_vld", {24'd0, bus.outp_vld}, 32'h08);
    chk("uni_outp3", {16'd0, outs[3]}, 32'hA5A5);
    chk("uni_outp0", {16'd0, outs[0]}, 32'h0);
    chk("uni_outp4", {16'd0, outs[4]}, 32'h0);
    chk("uni_busy", {31'd0, bus.busy}, 32'd1);
    step();
    chk("uni_vld_off", {24'd0, bus.outp_vld}, 32'h0);
    chk("uni_cnt", {16'd0, bus.done_cnt}, 32'd1);
    chk("uni_busy_off", {31'd0, bus.busy}, 32'd0);

    // Backpressure, with the next word waiting upstream
    bus.outp_rdy = 8'h00;
    put_word(16'h0BEE, 3'd6, 1'b0);
    bus.inp     = 16'h7777;
    bus.sel     = 3'd1;
    bus.inp_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_vld", {24'd0, bus.outp_vld}, 32'h40);
      chk("bp_rdy", {31'd0, bus.inp_rdy}, 32'd0);
      chk("bp_data", {16'd0, outs[6]}, 32'h0BEE);
      chk("bp_cnt", {16'd0, bus.done_cnt}, 32'd1);
    end
    @(posedge clk);
    #1;
    bus.outp_rdy = 8'h40;
    #1;
    chk("bp_rdy_comb", {31'd0, bus.inp_rdy}, 32'd1);
    step();
    bus.inp_vld = 1'b0;
    chk("swap_vld", {24'd0, bus.outp_vld}, 32'h02);
    chk("swap_outp1", {16'd0, outs[1]}, 32'h7777);
    chk("swap_outp6", {16'd0, outs[6]}, 32'h0);
    chk("swap_cnt", {16'd0, bus.done_cnt}, 32'd2);
    bus.outp_rdy = 8'h02;
    step();
    chk("swap_done_vld", {24'd0, bus.outp_vld}, 32'h0);
    chk("swap_done_cnt", {16'd0, bus.done_cnt}, 32'd3);

    // Broadcast with staggered acceptance
    bus.outp_rdy = 8'h0F;
    put_word(16'h1234, 3'd0, 1'b1);
    @(negedge clk);
    chk("bc_vld0", {24'd0, bus.outp_vld}, 32'hFF);
    chk("bc_outp7", {16'd0, outs[7]}, 32'h1234);
    chk("bc_cnt0", {16'd0, bus.done_cnt}, 32'd3);
    @(posedge clk);
    #1;
    bus.outp_rdy = 8'h30;
    @(negedge clk);
    chk("bc_vld1", {24'd0, bus.outp_vld}, 32'hF0);
    chk("bc_outp0", {16'd0, outs[0]}, 32'h0);
    chk("bc_cnt1", {16'd0, bus.done_cnt}, 32'd3);
    @(posedge clk);
    #1;
    bus.outp_rdy = 8'hC0;
    @(negedge clk);
    chk("bc_vld2", {24'd0, bus.outp_vld}, 32'hC0);
    chk("bc_cnt2", {16'd0, bus.done_cnt}, 32'd3);
    chk("bc_rdy2", {31'd0, bus.inp_rdy}, 32'd1);
    step();
    chk("bc_vld3", {24'd0, bus.outp_vld}, 32'h00);
    chk("bc_cnt3", {16'd0, bus.done_cnt}, 32'd4);

    // Streaming one word per cycle; also carries the counter up to its top value
    bus.outp_rdy = 8'hFF;
    n = 65531;
    for (int k = 0; k < n; k++) begin
      bus.inp     = 16'($urandom_range(0, 65535));
      bus.sel     = 3'(k);
      bus.inp_vld = 1'b1;
      @(negedge clk);
      if (k >= 1 && k <= 16) begin
        chk("st_vld", {24'd0, bus.outp_vld}, 32'd1 << ((k - 1) % 8));
        chk("st_cnt", {16'd0, bus.done_cnt}, 32'(4 + k - 1));
        chk("st_rdy", {31'd0, bus.inp_rdy}, 32'd1);
      end
      @(posedge clk);
      #1;
    end
    bus.inp_vld = 1'b0;
    @(negedge clk);
    chk("st_last_vld", {24'd0, bus.outp_vld}, 32'd1 << ((n - 1) % 8));
    chk("st_last_cnt", {16'd0, bus.done_cnt}, 32'd65534);
    step();
    chk("st_end_cnt", {16'd0, bus.done_cnt}, 32'd65535);
    chk("st_end_vld", {24'd0, bus.outp_vld}, 32'h0);

    // Counter wrap
    put_word(16'h5A5A, 3'd5, 1'b0);
    @(negedge clk);
    chk("wrap_vld", {24'd0, bus.outp_vld}, 32'h20);
    chk("wrap_pre", {16'd0, bus.done_cnt}, 32'd65535);
    step();
    chk("wrap_cnt", {16'd0, bus.done_cnt}, 32'd0);
    chk("wrap_busy", {31'd0, bus.busy}, 32'd0);
    chk("wrap_state", {31'd0, state}, {31'd0, st_empty});

    repeat (2) step();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
